axi4_burst_mem_slave: RTL and testbench



---
 rtl/axi4_burst_mem_slave.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst responder backed by a word-addressed RAM with byte enables.
// Independent write and read FSMs, one burst in flight per direction.
module axi4_burst_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH   = 1 << WORD_AW;
  localparam int unsigned CNT_W   = 9;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [31:0] mem [DEPTH];

  // byte-lane offsets within a word are not used for addressing
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------- write path ----------------
  w_state_t              w_state, w_state_n;
  logic [WORD_AW-1:0]    w_addr, w_addr_n;
  logic [CNT_W-1:0]      w_rem, w_rem_n;
  logic                  w_fixed, w_fixed_n;
  logic                  w_unsup, w_unsup_n;
  logic                  w_err, w_err_n;
  logic                  awready_n, wready_n, bvalid_n;
  logic [1:0]            bresp_n;
  logic [ID_WIDTH-1:0]   bid_n;
  logic                  mem_we;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      w_state       <= W_IDLE;
      w_addr        <= '0;
      w_rem         <= '0;
      w_fixed       <= 1'b0;
      w_unsup       <= 1'b0;
      w_err         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
    end else begin
      w_state       <= w_state_n;
      w_addr        <= w_addr_n;
      w_rem         <= w_rem_n;
      w_fixed       <= w_fixed_n;
      w_unsup       <= w_unsup_n;
      w_err         <= w_err_n;
      s_axi_awready <= awready_n;
      s_axi_wready  <= wready_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_bresp   <= bresp_n;
      s_axi_bid     <= bid_n;
    end
  end

  always_comb begin
    w_state_n = w_state;
    w_addr_n  = w_addr;
    w_rem_n   = w_rem;
    w_fixed_n = w_fixed;
    w_unsup_n = w_unsup;
    w_err_n   = w_err;
    awready_n = s_axi_awready;
    wready_n  = s_axi_wready;
    bvalid_n  = s_axi_bvalid;
    bresp_n   = s_axi_bresp;
    bid_n     = s_axi_bid;
    mem_we    = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_n = 1'b1;
        if (s_axi_awready && s_axi_awvalid) begin
          awready_n = 1'b0;
          wready_n  = 1'b1;
          bid_n     = s_axi_awid;
          w_addr_n  = s_axi_awaddr[ADDR_WIDTH-1:2];
          w_rem_n   = CNT_W'(s_axi_awlen) + CNT_W'(1);
          w_fixed_n = (s_axi_awburst == BURST_FIXED);
          w_unsup_n = (s_axi_awsize != 3'd2) || s_axi_awburst[1];
          w_err_n   = 1'b0;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wready && s_axi_wvalid) begin
          mem_we  = !w_unsup;
          w_rem_n = w_rem - CNT_W'(1);
          if (!w_fixed) w_addr_n = w_addr + WORD_AW'(1);
          // length comes from awlen; wlast only grades the response
          if (w_rem == CNT_W'(1)) begin
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = (w_unsup || w_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
            w_state_n = W_RESP;
          end else if (s_axi_wlast) begin
            w_err_n = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bvalid && s_axi_bready) begin
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OKAY;
          awready_n = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // RAM keeps its contents across reset
  always_ff @(posedge sys_clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[w_addr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state, r_state_n;
  logic [WORD_AW-1:0]    r_addr, r_addr_n;
  logic [CNT_W-1:0]      r_rem, r_rem_n;
  logic                  r_fixed, r_fixed_n;
  logic                  r_unsup, r_unsup_n;
  logic                  arready_n, rvalid_n, rlast_n;
  logic [1:0]            rresp_n;
  logic [31:0]           rdata_n;
  logic [ID_WIDTH-1:0]   rid_n;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_rem         <= '0;
      r_fixed       <= 1'b0;
      r_unsup       <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
    end else begin
      r_state       <= r_state_n;
      r_addr        <= r_addr_n;
      r_rem         <= r_rem_n;
      r_fixed       <= r_fixed_n;
      r_unsup       <= r_unsup_n;
      s_axi_arready <= arready_n;
      s_axi_rvalid  <= rvalid_n;
      s_axi_rlast   <= rlast_n;
      s_axi_rresp   <= rresp_n;
      s_axi_rdata   <= rdata_n;
      s_axi_rid     <= rid_n;
    end
  end

  always_comb begin
    r_state_n = r_state;
    r_addr_n  = r_addr;
    r_rem_n   = r_rem;
    r_fixed_n = r_fixed;
    r_unsup_n = r_unsup;
    arready_n = s_axi_arready;
    rvalid_n  = s_axi_rvalid;
    rlast_n   = s_axi_rlast;
    rresp_n   = s_axi_rresp;
    rdata_n   = s_axi_rdata;
    rid_n     = s_axi_rid;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (s_axi_arready && s_axi_arvalid) begin
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rid_n     = s_axi_arid;
          r_addr_n  = s_axi_araddr[ADDR_WIDTH-1:2];
          r_rem_n   = CNT_W'(s_axi_arlen) + CNT_W'(1);
          r_fixed_n = (s_axi_arburst == BURST_FIXED);
          r_unsup_n = (s_axi_arsize != 3'd2) || s_axi_arburst[1];
          rlast_n   = (s_axi_arlen == 8'd0);
          rresp_n   = r_unsup_n ? RESP_SLVERR : RESP_OKAY;
          rdata_n   = r_unsup_n ? 32'd0 : mem[r_addr_n];
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (s_axi_rlast) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            rresp_n   = RESP_OKAY;
            rdata_n   = 32'd0;
            arready_n = 1'b1;
            r_state_n = R_IDLE;
          end else begin
            if (!r_fixed) r_addr_n = r_addr + WORD_AW'(1);
            r_rem_n = r_rem - CNT_W'(1);
            rlast_n = (r_rem == CNT_W'(2));
            rdata_n = r_unsup ? 32'd0 : mem[r_addr_n];
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: bursts, strobes, FIXED, errors,
// address wrap, throttling and mid-burst reset, checked with immediate asserts.
module tb_axi4_burst_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awid, arid, bid, rid;
  logic [11:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  logic [31:0] wbuf [256];
  logic [31:0] ebuf [256];
  int n_pass = 0, n_total = 0, n_fail = 0;

  always #5 clk = ~clk;

  axi4_burst_mem_slave #(.ADDR_WIDTH(12), .ID_WIDTH(4)) dut (
    .sys_clock(clk), .reset(reset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_hs(input logic [11:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt);
    bit hs;
    int cyc;
    awid = 4'h3; awaddr = a; awlen = 8'(len); awsize = sz; awburst = bt; awvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 100) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; cyc++;
    end
    awvalid = 1'b0;
    if (!hs) check("aw_timeout", 32'd0, 32'd1);
  endtask

  // Writes wbuf[0..len]; wlast is driven on beat last_at.
  task automatic wr(input logic [11:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt,
                    input logic [3:0] strb, input int last_at, input bit thr, output logic [1:0] resp);
    bit hs;
    int i, cyc;
    aw_hs(a, len, sz, bt);
    i = 0; cyc = 0; wvalid = 1'b0;
    while (i <= len && cyc < 5000) begin
      if (!wvalid) wvalid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
      @(negedge clk); hs = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (hs) begin i++; wvalid = 1'b0; end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (i <= len) check("w_timeout", 32'(i), 32'(len + 1));
    if (thr) repeat ($urandom_range(0, 3)) @(posedge clk);
    #1; bready = 1'b1; hs = 1'b0; cyc = 0; resp = 2'bxx;
    while (!hs && cyc < 100) begin
      @(negedge clk); hs = bvalid; resp = bresp;
      if (hs) check("bid", 32'(bid), 32'h3);
      @(posedge clk); #1; cyc++;
    end
    bready = 1'b0;
    if (!hs) check("b_timeout", 32'd0, 32'd1);
  endtask

  // Reads len+1 beats and compares against ebuf / exp_resp.
  task automatic rd(input logic [11:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt,
                    input logic [1:0] exp_resp, input bit thr, input string tag);
    bit hs, stalled;
    int i, cyc;
    logic [31:0] held;
    arid = 4'h9; araddr = a; arlen = 8'(len); arsize = sz; arburst = bt; arvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 100) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; cyc++;
    end
    arvalid = 1'b0;
    if (!hs) check("ar_timeout", 32'd0, 32'd1);
    i = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (i <= len && cyc < 5000) begin
      rready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rvalid) begin
        if (stalled) check({tag, "_stable"}, rdata, held);
        if (rready) begin
          check({tag, "_data"}, rdata, ebuf[i]);
          check({tag, "_resp"}, 32'(rresp), 32'(exp_resp));
          check({tag, "_last"}, 32'(rlast), 32'(i == len));
          check({tag, "_rid"}, 32'(rid), 32'h9);
          i++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = rdata;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    rready = 1'b0;
    if (i <= len) check({tag, "_timeout"}, 32'(i), 32'(len + 1));
  endtask

  task automatic big_traffic(input bit thr);
    logic [1:0] resp;
    for (int i = 0; i < 256; i++) wbuf[i] = 32'(i);
    wr(12'h008, 255, 3'd2, 2'b01, 4'hF, 255, thr, resp);
    check("big_bresp", 32'(resp), 32'd0);
    for (int k = 0; k < 256; k++) ebuf[k] = (k >= 2) ? 32'(k - 2) : 32'd0;
    rd(12'h000, 255, 3'd2, 2'b01, 2'b00, thr, "rd_lo");
    for (int k = 0; k < 256; k++) ebuf[k] = (k < 2) ? 32'(k + 254) : 32'd0;
    rd(12'h400, 255, 3'd2, 2'b01, 2'b00, thr, "rd_hi");
  endtask

  initial begin
    logic [1:0] resp;
    reset = 1'b1;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_valids", 32'({wready, bvalid, rvalid, rlast}), 32'd0);
    check("rst_payload", rdata | 32'(bresp) | 32'(rresp) | 32'(bid) | 32'(rid), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("awready_pre", 32'(awready), 32'd0);
    @(posedge clk); #1;
    check("awready_up", 32'(awready), 32'd1);
    check("arready_up", 32'(arready), 32'd1);

    // zero the whole RAM
    for (int i = 0; i < 256; i++) wbuf[i] = 32'd0;
    for (int q = 0; q < 4; q++) wr(12'(q * 12'h400), 255, 3'd2, 2'b01, 4'hF, 255, 1'b0, resp);

    big_traffic(1'b0);
    big_traffic(1'b1);

    // byte strobes
    wbuf[0] = 32'hAABBCCDD;
    wr(12'h010, 0, 3'd2, 2'b01, 4'hF, 0, 1'b0, resp);
    wbuf[0] = 32'h11223344;
    wr(12'h010, 0, 3'd2, 2'b01, 4'h5, 0, 1'b0, resp);
    check("strb_bresp", 32'(resp), 32'd0);
    ebuf[0] = 32'hAA22CC44;
    rd(12'h010, 0, 3'd2, 2'b01, 2'b00, 1'b0, "strb");

    // FIXED write lands only in word 8
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    wr(12'h020, 3, 3'd2, 2'b00, 4'hF, 3, 1'b0, resp);
    check("fixed_bresp", 32'(resp), 32'd0);
    ebuf[0] = 32'd4; ebuf[1] = 32'd7; ebuf[2] = 32'd8; ebuf[3] = 32'd9;
    rd(12'h020, 3, 3'd2, 2'b01, 2'b00, 1'b0, "fixed_incr");
    for (int i = 0; i < 4; i++) ebuf[i] = 32'd4;
    rd(12'h020, 3, 3'd2, 2'b00, 2'b00, 1'b0, "fixed_rd");

    // unsupported size: error and no write
    wbuf[0] = 32'hDEADBEEF;
    wr(12'h010, 0, 3'd1, 2'b01, 4'hF, 0, 1'b0, resp);
    check("size_bresp", 32'(resp), 32'd2);
    ebuf[0] = 32'hAA22CC44;
    rd(12'h010, 0, 3'd2, 2'b01, 2'b00, 1'b0, "size_keep");

    // WRAP read: two zero beats with SLVERR
    ebuf[0] = 32'd0; ebuf[1] = 32'd0;
    rd(12'h020, 1, 3'd2, 2'b10, 2'b10, 1'b0, "wrap_rd");

    // early wlast on beat 2 of 4
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h100 + 32'(i);
    wr(12'h030, 3, 3'd2, 2'b01, 4'hF, 1, 1'b0, resp);
    check("early_last_bresp", 32'(resp), 32'd2);

    // burst crossing the top of the RAM wraps to word 0
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); ebuf[i] = 32'hA0 + 32'(i); end
    wr(12'hFF8, 3, 3'd2, 2'b01, 4'hF, 3, 1'b0, resp);
    check("topwrap_bresp", 32'(resp), 32'd0);
    rd(12'hFF8, 3, 3'd2, 2'b01, 2'b00, 1'b0, "topwrap");

    // reset during beat 10 of a 256-beat write
    aw_hs(12'h000, 255, 3'd2, 2'b01);
    for (int i = 0; i < 10; i++) begin
      wvalid = 1'b1; wstrb = 4'hF; wlast = 1'b0; wdata = 32'h5000 + 32'(i);
      @(negedge clk);
      check("pre_rst_wready", 32'(wready), 32'd1);
      @(posedge clk); #1;
    end
    wdata = 32'h500A;
    #2 reset = 1'b1;
    #1;
    check("midrst_outs", 32'({awready, wready, bvalid, arready, rvalid, rlast}), 32'd0);
    @(posedge clk); #1; reset = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    check("midrst_awready", 32'(awready), 32'd1);
    for (int i = 0; i < 256; i++) wbuf[i] = 32'h7000 + 32'(i);
    wr(12'h800, 255, 3'd2, 2'b01, 4'hF, 255, 1'b0, resp);
    check("post_rst_bresp", 32'(resp), 32'd0);
    for (int i = 0; i < 10; i++) ebuf[i] = 32'h5000 + 32'(i);
    rd(12'h000, 9, 3'd2, 2'b01, 2'b00, 1'b0, "kept");
    for (int i = 0; i < 4; i++) ebuf[i] = 32'h7000 + 32'(i);
    rd(12'h800, 3, 3'd2, 2'b01, 2'b00, 1'b1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
